pet_clk_enables: RTL and testbench
==================================

Name: pet_clk_enables

Overview:
- Timing generator for the PET clone core. From the single system clock it produces one-cycle-wide clock-enable strobes at 16 MHz, 8 MHz and 1 MHz, plus a 1 MHz phase counter.
- Video (clk16/clk8) and CPU/CRTC bus logic (clk1n, clk1) qualify their registers with these strobes. There are no derived clocks.
- All strobes are phase-locked to one free-running divider, so edges coincide deterministically.

Parameters:
- SYS_CLOCK_MHZ, 64: system clock frequency in MHz. Must be a power of two and at least 16.
- Derived localparams: DIV16 = SYS_CLOCK_MHZ/16, DIV8 = SYS_CLOCK_MHZ/8, DIV1 = SYS_CLOCK_MHZ, CNT_W = log2(DIV1).

Ports:
- sys_clock_i  input  1  system clock; all logic on its rising edge.
- reset_i  input  1  synchronous reset, active-high.
- clk16_en_o  output  1  one-cycle strobe at 16 MHz.
- clk8_en_o  output  1  one-cycle strobe at 8 MHz.
- clk1n_en_o  output  1  one-cycle strobe at 1 MHz, falling phase of the CPU clock. Bus/register sampling point.
- clk1_en_o  output  1  one-cycle strobe at 1 MHz, rising phase, half a period after clk1n_en_o.
- cpu_clk_o  output  1  1 MHz 50% square wave for monitoring.
- phase_o  output  CNT_W  current divider count within the 1 MHz period.

Behaviour:
- The interface is one clock (sys_clock_i) and one reset. Reset is synchronous and active-high: reset_i is sampled only on the rising edge of sys_clock_i.
- Divider:
  - Free-running CNT_W-bit counter `cnt`, incremented every sys_clock_i cycle, wrapping from DIV1-1 to 0.
  - With the default, 6 bits, 0..63.
- Strobes are registered outputs, decoded from `cnt` before increment. Each asserts for exactly one sys_clock_i cycle:
  - clk16_en_o = 1 in the cycle after cnt[log2(DIV16)-1:0] == all-ones (default: every 4 cycles).
  - clk8_en_o = 1 in the cycle after cnt[log2(DIV8)-1:0] == all-ones (default: every 8 cycles).
  - clk1n_en_o = 1 in the cycle after cnt == DIV1-1 (default: every 64 cycles).
  - clk1_en_o = 1 in the cycle after cnt == DIV1/2-1.
- Alignment guarantees:
  - Every clk8_en_o pulse coincides with a clk16_en_o pulse.
  - Every clk1n_en_o pulse and every clk1_en_o pulse coincides with both clk8_en_o and clk16_en_o.
  - clk1n_en_o and clk1_en_o are never high together.
- cpu_clk_o is registered:
  - Set to 1 on the clk1_en_o cycle.
  - Cleared to 0 on the clk1n_en_o cycle.
- phase_o = registered copy of `cnt`, equal to 0 in the same cycle clk1n_en_o is high.
- Reset:
  - cnt = 0, all strobes = 0, cpu_clk_o = 0, phase_o = 0.
  - First clk16_en_o pulse: DIV16 cycles after reset release.
  - First clk8_en_o pulse: DIV8 cycles after release.
  - First clk1_en_o pulse: DIV1/2 cycles after release.
  - First clk1n_en_o pulse: DIV1 cycles after release.
- Reset mid-period: any pending strobe is suppressed. The phase restarts from 0 with the latencies above, with no glitch or double pulse.
- Reset held for several cycles keeps all outputs at 0.
- No combinational paths from inputs to outputs.

Decomposition:
- common_pkg holds:
  - SYS_CLOCK_MHZ (shared default).
  - A function clk_div_bits(mhz) returning log2 of a divisor.
- One natural sub-module: pet_clk_divider.
  - Parameterized counter with wrap and an "at terminal count" output for a given bit-slice.
  - Instantiated once; the strobe decoders are thin logic in the top.

Test Plan:
- Reset release, default params:
  - First clk16_en_o at cycle 4, clk8_en_o at cycle 8, clk1_en_o at cycle 32, clk1n_en_o at cycle 64.
  - All outputs 0 while reset is held.
- Period check over 10 µs with a stopwatch on posedges:
  - clk16_en_o period 62.5 ns, clk8_en_o 125 ns, clk1n_en_o 1000 ns.
  - Every pulse exactly 1 sys cycle (15.625 ns) wide.
- Alignment:
  - On every clk1n_en_o high cycle, clk8_en_o = clk16_en_o = 1 and phase_o = 0.
  - clk1_en_o high ⇒ phase_o = 32.
  - clk1n_en_o and clk1_en_o never both 1.
- cpu_clk_o: 500 ns high / 500 ns low; rises with clk1_en_o, falls with clk1n_en_o.
- Reset asserted at phase 40 for 3 cycles:
  - No clk1n_en_o pulse at the old schedule.
  - Next clk1n_en_o exactly 64 cycles after release.
- SYS_CLOCK_MHZ=32 override:
  - clk16_en_o every 2 cycles, clk8_en_o every 4 cycles, clk1n_en_o every 32 cycles.
  - phase_o is 5 bits.

Source files
------------

// File: rtl/pet_clk_enables_pkg.sv
// Shared timing constants, the strobe bundle type and divider helper functions for the PET clock enables.
// Everything here is compile-time only and holds no state.
package pet_clk_enables_pkg;

  localparam int SYS_CLOCK_MHZ = 64;

  typedef struct packed {
    logic clk16;
    logic clk8;
    logic clk1n;
    logic clk1;
  } strobe_t;

  // log2 of a power-of-two divisor
  function automatic int clk_div_bits(input int mhz);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < mhz) b = i + 1;
    end
    return b;
  endfunction

  // True when the low 'bits' bits of v are all ones; zero bits is always true
  function automatic logic low_ones(input logic [31:0] v, input int bits);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r = r & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pet_clk_divider.sv
// Free-running wrap-around counter with a terminal-count flag over its low TC_W bits.
// Count advances every cycle; no backpressure, synchronous reset to zero.
module pet_clk_divider #(
  parameter int CNT_W = 6,
  parameter int TC_W  = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + CNT_W'(1);
  end

  assign tc = &cnt[TC_W-1:0];

endmodule

// File: rtl/pet_clk_enables.sv
// 16/8/1 MHz one-cycle clock-enable strobes and 1 MHz phase, all phase-locked to one divider.
// Strobes are registered one cycle after the decoded count; no backpressure.
module pet_clk_enables #(
  parameter int SYS_CLOCK_MHZ = pet_clk_enables_pkg::SYS_CLOCK_MHZ,
  localparam int CNT_W = pet_clk_enables_pkg::clk_div_bits(SYS_CLOCK_MHZ)
) (
  input  logic             sys_clock_i,
  input  logic             reset_i,
  output logic             clk16_en_o,
  output logic             clk8_en_o,
  output logic             clk1n_en_o,
  output logic             clk1_en_o,
  output logic             cpu_clk_o,
  output logic [CNT_W-1:0] phase_o
);
  import pet_clk_enables_pkg::*;

  localparam int DIV16 = SYS_CLOCK_MHZ / 16;
  localparam int DIV8  = SYS_CLOCK_MHZ / 8;
  localparam int DIV1  = SYS_CLOCK_MHZ;
  localparam int B16   = clk_div_bits(DIV16);
  localparam int B8    = clk_div_bits(DIV8);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(DIV1 / 2 - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  strobe_t          dec;
  strobe_t          strb;
  logic             cpu_clk;

  pet_clk_divider #(
    .CNT_W(CNT_W),
    .TC_W (CNT_W)
  ) u_div (
    .clk(sys_clock_i),
    .rst(reset_i),
    .cnt(cnt),
    .tc (wrap)
  );

  // Decode the pre-increment count so each strobe lands on the cycle the count wraps its slice
  always_comb begin
    dec       = '0;
    dec.clk16 = low_ones(32'(cnt), B16);
    dec.clk8  = low_ones(32'(cnt), B8);
    dec.clk1n = wrap;
    dec.clk1  = (cnt == HALF_TC);
  end

  always_ff @(posedge sys_clock_i) begin
    if (reset_i) begin
      strb    <= '0;
      cpu_clk <= 1'b0;
    end else begin
      strb <= dec;
      if (dec.clk1)       cpu_clk <= 1'b1;
      else if (dec.clk1n) cpu_clk <= 1'b0;
    end
  end

  assign clk16_en_o = strb.clk16;
  assign clk8_en_o  = strb.clk8;
  assign clk1n_en_o = strb.clk1n;
  assign clk1_en_o  = strb.clk1;
  assign cpu_clk_o  = cpu_clk;
  // The divider count is already a register, so it doubles as the phase output
  assign phase_o    = cnt;

endmodule

// File: tb/tb_pet_clk_enables.sv
// Directed bench for pet_clk_enables at 64 MHz and 32 MHz system clocks.
`timescale 1ns/1ps
module tb_pet_clk_enables;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #8 clk = ~clk;

  logic       a16, a8, a1n, a1, acpu;
  logic [5:0] aph;
  logic       b16, b8, b1n, b1, bcpu;
  logic [4:0] bph;

  pet_clk_enables #(.SYS_CLOCK_MHZ(64)) dut (
    .sys_clock_i(clk), .reset_i(rst),
    .clk16_en_o(a16), .clk8_en_o(a8), .clk1n_en_o(a1n), .clk1_en_o(a1),
    .cpu_clk_o(acpu), .phase_o(aph)
  );

  pet_clk_enables #(.SYS_CLOCK_MHZ(32)) dut32 (
    .sys_clock_i(clk), .reset_i(rst),
    .clk16_en_o(b16), .clk8_en_o(b8), .clk1n_en_o(b1n), .clk1_en_o(b1),
    .cpu_clk_o(bcpu), .phase_o(bph)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k;
  int last16, last8, last1n, last1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_watch();
    k = 0;
    last16 = -1; last8 = -1; last1n = -1; last1 = -1;
  endtask

  // Stopwatch: the first pulse after release must land at 'first', later ones 'per' apart
  task automatic watch(input string tag, input logic p, inout int last, input int first, input int per);
    if (p) begin
      if (last < 0) chk({tag, "_first"}, 32'(k), 32'(first));
      else          chk({tag, "_period"}, 32'(k - last), 32'(per));
      last = k;
    end
  endtask

  // k counts rising edges since reset release; expectations are closed-form in k
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      k++;
      chk("clk16",  32'(a16),  32'((k % 4) == 0));
      chk("clk8",   32'(a8),   32'((k % 8) == 0));
      chk("clk1",   32'(a1),   32'((k % 64) == 32));
      chk("clk1n",  32'(a1n),  32'((k % 64) == 0));
      chk("cpuclk", 32'(acpu), 32'((k % 64) >= 32));
      chk("phase",  32'(aph),  32'(k % 64));
      chk("b_clk16",  32'(b16),  32'((k % 2) == 0));
      chk("b_clk8",   32'(b8),   32'((k % 4) == 0));
      chk("b_clk1",   32'(b1),   32'((k % 32) == 16));
      chk("b_clk1n",  32'(b1n),  32'((k % 32) == 0));
      chk("b_cpuclk", 32'(bcpu), 32'((k % 32) >= 16));
      chk("b_phase",  32'(bph),  32'(k % 32));
      if (a1n) chk("align1n", 32'({a16, a8, aph}), 32'({2'b11, 6'd0}));
      if (a1)  chk("align1",  32'({a16, a8, aph}), 32'({2'b11, 6'd32}));
      if (a1 || a1n) chk("excl1", 32'(a1 & a1n), 32'(0));
      watch("p16", a16, last16, 4, 4);
      watch("p8",  a8,  last8,  8, 8);
      watch("p1",  a1,  last1,  32, 64);
      watch("p1n", a1n, last1n, 64, 64);
    end
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("reset_out", 32'({a16, a8, a1n, a1, acpu, aph, b16, b8, b1n, b1, bcpu, bph}), 32'(0));
    end
    rst = 1'b0;
    clear_watch();
  endtask

  initial begin
    clear_watch();
    hold_reset(3);

    // 10 us at 64 MHz plus the 32 MHz instance alongside
    run(640);
    chk("pulses_seen", 32'({last16 > 0, last8 > 0, last1 > 0, last1n > 0}), 32'(4'b1111));

    // Interrupt mid-period at phase 40; the old schedule would give clk1n 24 cycles later
    run(40);
    chk("phase_before_rst", 32'(aph), 32'(40));
    hold_reset(3);
    run(70);
    chk("post_rst_1n", 32'(last1n), 32'(64));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
